exe_hazard_ctrl: RTL

Pipeline sequencing controller for the execute stage. It keeps a registered scoreboard of the instructions in EXE, MEM and WB, and from it generates the IF/ID stall, the branch flush and the bubble insertion. It also owns the architectural status register that feeds the EXE carry-in and condition checking. It sits beside the ID/EXE pipeline registers and sequences the EXE datapath (ALU, Val2 generator, branch adder); it does not compute data.

---
 rtl/exe_hazard_ctrl_pkg.sv | 32 +++
 rtl/exe_hazard_ctrl_hazard_cmp.sv | 16 +
 rtl/exe_hazard_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/exe_hazard_ctrl_pkg.sv
// Shared types and constants for the execute-stage hazard controller.
package exe_hazard_ctrl_pkg;

    // Register index width.
    localparam int REG_W = 4;

    // Status register bit positions, {N,Z,C,V}.
    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;

    // Scoreboard depth and stage slots.
    localparam int N_STAGES = 3;
    localparam int STG_EXE  = 0;
    localparam int STG_MEM  = 1;
    localparam int STG_WB   = 2;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic             valid;
        logic             wb_en;
        logic             mem_r;
        logic             s;
        logic             branch;
        logic [REG_W-1:0] dest;
    } sb_tag_t;

    // Empty slot: a bubble never hits, flushes or updates status.
    localparam sb_tag_t TAG_BUBBLE = '0;

endpackage

// File: rtl/exe_hazard_ctrl_hazard_cmp.sv
// Read-after-write hit check of one source operand against one scoreboard tag.
module hazard_cmp
    import exe_hazard_ctrl_pkg::*;
(
    input  logic             tag_valid,
    input  logic             tag_wb_en,
    input  logic [REG_W-1:0] tag_dest,
    input  logic             src_en,
    input  logic [REG_W-1:0] src,
    output logic             hit
);

    // A source hits only a live tag that writes the register being read.
    assign hit = src_en && tag_valid && tag_wb_en && (tag_dest == src);

endmodule

// File: rtl/exe_hazard_ctrl.sv
// Execute-stage sequencing: scoreboard of EXE/MEM/WB, stall, flush and status register.
module exe_hazard_ctrl
    import exe_hazard_ctrl_pkg::*;
#(
    parameter int FORWARDING = 0,
    parameter int REG_W      = exe_hazard_ctrl_pkg::REG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic             id_src1_en,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic             id_s,
    input  logic             id_branch,
    input  logic [3:0]       exe_status,
    output logic             stall,
    output logic             flush,
    output logic [3:0]       SR
);

    sb_tag_t    tags_q [N_STAGES];
    sb_tag_t    tags_d [N_STAGES];
    logic [3:0] sr_q;
    logic [3:0] sr_d;

    sb_tag_t    id_tag;
    logic [1:0] exe_hit;   // [0] src1, [1] src2
    logic [1:0] mem_hit;
    logic       raw_hazard;

    hazard_cmp u_cmp_exe_src1 (
        .tag_valid (tags_q[STG_EXE].valid),
        .tag_wb_en (tags_q[STG_EXE].wb_en),
        .tag_dest  (tags_q[STG_EXE].dest),
        .src_en    (id_src1_en),
        .src       (id_src1),
        .hit       (exe_hit[0])
    );

    hazard_cmp u_cmp_exe_src2 (
        .tag_valid (tags_q[STG_EXE].valid),
        .tag_wb_en (tags_q[STG_EXE].wb_en),
        .tag_dest  (tags_q[STG_EXE].dest),
        .src_en    (id_two_src),
        .src       (id_src2),
        .hit       (exe_hit[1])
    );

    hazard_cmp u_cmp_mem_src1 (
        .tag_valid (tags_q[STG_MEM].valid),
        .tag_wb_en (tags_q[STG_MEM].wb_en),
        .tag_dest  (tags_q[STG_MEM].dest),
        .src_en    (id_src1_en),
        .src       (id_src1),
        .hit       (mem_hit[0])
    );

    hazard_cmp u_cmp_mem_src2 (
        .tag_valid (tags_q[STG_MEM].valid),
        .tag_wb_en (tags_q[STG_MEM].wb_en),
        .tag_dest  (tags_q[STG_MEM].dest),
        .src_en    (id_two_src),
        .src       (id_src2),
        .hit       (mem_hit[1])
    );

    // Stall and flush are combinational from the held tags; a taken branch in EXE
    // discards the ID instruction, so its hazard must not also stall.
    always_comb begin
        flush = tags_q[STG_EXE].valid && tags_q[STG_EXE].branch;
        if (FORWARDING != 0) begin
            // Only a load result cannot be forwarded from EXE in time.
            raw_hazard = (|exe_hit) && tags_q[STG_EXE].mem_r;
        end else begin
            // Without bypass paths, wait until the producer reaches WB
            // (the register file writes on the negedge).
            raw_hazard = (|exe_hit) || (|mem_hit);
        end
        stall = id_valid && raw_hazard && !flush;
    end

    // Pack the ID fields into the tag that would enter EXE.
    always_comb begin
        id_tag        = TAG_BUBBLE;
        id_tag.valid  = 1'b1;
        id_tag.wb_en  = id_wb_en;
        id_tag.mem_r  = id_mem_r_en;
        id_tag.s      = id_s;
        id_tag.branch = id_branch;
        id_tag.dest   = id_dest;
    end

    // Next scoreboard and status: shift when not frozen, bubble on stall/flush/empty ID.
    always_comb begin
        // NOTE: hold-by-default assignment first keeps every path covered, so no latch is inferred.
        tags_d = tags_q;
        sr_d   = sr_q;
        if (!freeze) begin
            tags_d[STG_WB]  = tags_q[STG_MEM];
            tags_d[STG_MEM] = tags_q[STG_EXE];
            tags_d[STG_EXE] = (stall || flush || !id_valid) ? TAG_BUBBLE : id_tag;
            if (tags_q[STG_EXE].valid && tags_q[STG_EXE].s) begin
                sr_d = exe_status;
            end
        end
    end

    // State registers with synchronous reset of all in-flight tags and the status.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the tag array is control state, not data storage, so every entry is reset;
            // a stale valid tag would raise a phantom stall or flush.
            for (int i = 0; i < N_STAGES; i++) begin
                tags_q[i] <= TAG_BUBBLE;
            end
            sr_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all stages sample the pre-edge values.
            tags_q <= tags_d;
            sr_q   <= sr_d;
        end
    end

    // SR[SR_C] is the carry-in consumed by the EXE ALU.
    assign SR = sr_q;

endmodule
